// File: rtl/decoder_pkg.sv
// Shared types and token helpers for the token decoder.
// A token is either a literal byte or a reference to a vocab merge pair.
package decoder_pkg;

  localparam int TOKEN_W           = 8;
  localparam int LITERAL_LIMIT_DEF = 248;

  typedef logic [TOKEN_W-1:0] token_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_TOK = 3'd1,
    S_LD_TOK = 3'd2,
    S_EXPAND = 3'd3,
    S_GET_R  = 3'd4,
    S_GET_L  = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  function automatic logic is_literal(input token_t tok, input token_t limit);
    return tok < limit;
  endfunction

  function automatic token_t merge_index(input token_t tok, input token_t limit);
    return tok - limit;
  endfunction

endpackage

// File: rtl/token_stack.sv
// LIFO holding tokens still waiting to be expanded.
// top is combinational from the current level; pushes when full are dropped.
module token_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic [LVL_W-1:0] level
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LVL_W-1:0] level_q, level_d;
  logic [IDX_W-1:0] wr_idx, top_idx;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_W'(DEPTH));
  assign level   = level_q;
  assign wr_idx  = IDX_W'(level_q);
  assign top_idx = IDX_W'(level_q - 1'b1);
  assign top     = empty ? '0 : mem_q[top_idx];

  always_comb begin
    level_d = level_q;
    if (clr)                level_d = '0;
    else if (push && !full) level_d = level_q + 1'b1;
    else if (pop && !empty) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) level_q <= '0;
    else     level_q <= level_d;
  end

  always_ff @(posedge clk) begin
    if (!clr && push && !full) mem_q[wr_idx] <= din;
  end

endmodule

// File: rtl/token_decoder.sv
// Expands token IDs into bytes by walking merge pairs in the vocab SRAM
// depth-first (left before right), writing bytes to the output SRAM.
module token_decoder
  import decoder_pkg::*;
#(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int LITERAL_LIMIT = LITERAL_LIMIT_DEF,
  parameter int STACK_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic [ADDR_WIDTH:0]   token_len,
  output logic [ADDR_WIDTH-1:0] tok_addr,
  input  logic [DATA_WIDTH-1:0] tok_dout,
  output logic [ADDR_WIDTH-1:0] voc_addr,
  input  logic [DATA_WIDTH-1:0] voc_dout,
  output logic                  out_we,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_din,
  output logic [ADDR_WIDTH:0]   out_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   tok_idx_q, tok_idx_d;
  logic [ADDR_WIDTH:0]   token_len_q, token_len_d;
  logic [ADDR_WIDTH:0]   out_len_q, out_len_d;
  logic [ADDR_WIDTH-2:0] m_q, m_d;

  logic                  stk_clr, stk_push, stk_pop, stk_empty, stk_full;
  logic [DATA_WIDTH-1:0] stk_din, stk_top;
  logic [LVL_W-1:0]      stk_level;
  token_t                merge_m;
  logic [DATA_WIDTH:0]   right_idx;
  logic                  we_c;

  token_stack #(.DEPTH(STACK_DEPTH), .WIDTH(DATA_WIDTH)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .clr   (stk_clr),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (stk_din),
    .top   (stk_top),
    .empty (stk_empty),
    .full  (stk_full),
    .level (stk_level)
  );

  assign merge_m   = merge_index(token_t'(stk_top), token_t'(LITERAL_LIMIT));
  assign right_idx = {merge_m, 1'b1};

  always_comb begin
    state_d     = state_q;
    tok_idx_d   = tok_idx_q;
    token_len_d = token_len_q;
    out_len_d   = out_len_q;
    m_d         = m_q;
    stk_clr     = 1'b0;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_din     = tok_dout;
    tok_addr    = '0;
    voc_addr    = '0;
    we_c        = 1'b0;
    out_addr    = '0;
    out_din     = '0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (cs) begin
          out_len_d   = '0;
          tok_idx_d   = '0;
          token_len_d = token_len;
          stk_clr     = 1'b1;
          state_d     = (token_len == '0) ? S_DONE : S_RD_TOK;
        end
      end
      S_RD_TOK: begin
        tok_addr = tok_idx_q[ADDR_WIDTH-1:0];
        state_d  = S_LD_TOK;
      end
      S_LD_TOK: begin
        if (stk_full) begin
          state_d = S_ERR;
        end else begin
          stk_push  = 1'b1;
          tok_idx_d = tok_idx_q + 1'b1;
          state_d   = S_EXPAND;
        end
      end
      S_EXPAND: begin
        stk_pop = 1'b1;
        if (stk_empty) begin
          state_d = S_ERR;
        end else if (is_literal(token_t'(stk_top), token_t'(LITERAL_LIMIT))) begin
          if (out_len_q == (ADDR_WIDTH+1)'(DEPTH)) begin
            state_d = S_ERR;
          end else begin
            we_c      = 1'b1;
            out_addr  = out_len_q[ADDR_WIDTH-1:0];
            out_din   = stk_top;
            out_len_d = out_len_q + 1'b1;
            // level is still the pre-pop count here
            if (stk_level != LVL_W'(1))       state_d = S_EXPAND;
            else if (tok_idx_q < token_len_q) state_d = S_RD_TOK;
            else                              state_d = S_DONE;
          end
        end else if (right_idx > (DATA_WIDTH+1)'(DEPTH - 1)) begin
          state_d = S_ERR;
        end else begin
          voc_addr = right_idx[ADDR_WIDTH-1:0];
          m_d      = merge_m[ADDR_WIDTH-2:0];
          state_d  = S_GET_R;
        end
      end
      S_GET_R: begin
        if (stk_full) begin
          state_d = S_ERR;
        end else begin
          stk_push = 1'b1;
          stk_din  = voc_dout;
          voc_addr = {m_q, 1'b0};
          state_d  = S_GET_L;
        end
      end
      S_GET_L: begin
        if (stk_full) begin
          state_d = S_ERR;
        end else begin
          stk_push = 1'b1;
          stk_din  = voc_dout;
          state_d  = S_EXPAND;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tok_idx_q   <= '0;
      token_len_q <= '0;
      out_len_q   <= '0;
      m_q         <= '0;
    end else begin
      state_q     <= state_d;
      tok_idx_q   <= tok_idx_d;
      token_len_q <= token_len_d;
      out_len_q   <= out_len_d;
      m_q         <= m_d;
    end
  end

  // A reset landing on an EXPAND cycle must not let that byte reach the SRAM.
  assign out_we  = we_c & ~rst;
  assign out_len = out_len_q;
  assign busy    = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
  assign done    = (state_q == S_DONE) || (state_q == S_ERR);
  assign err     = (state_q == S_ERR);

endmodule

// File: tb/tb_token_decoder.sv
// Directed bench for token_decoder with behavioural token/vocab/output SRAMs.
module tb_token_decoder;

  logic       clk = 1'b0;
  logic       rst, cs;
  logic [4:0] token_len;
  logic [3:0] tok_addr, voc_addr, out_addr;
  logic [7:0] tok_dout, voc_dout, out_din;
  logic       out_we, busy, done, err;
  logic [4:0] out_len;

  logic [7:0] tok_mem [16];
  logic [7:0] voc_mem [16];
  logic [7:0] out_mem [16];
  int         wr_cnt = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  token_decoder dut (
    .clk(clk), .rst(rst), .cs(cs), .token_len(token_len),
    .tok_addr(tok_addr), .tok_dout(tok_dout),
    .voc_addr(voc_addr), .voc_dout(voc_dout),
    .out_we(out_we), .out_addr(out_addr), .out_din(out_din),
    .out_len(out_len), .busy(busy), .done(done), .err(err)
  );

  always @(posedge clk) begin
    tok_dout <= tok_mem[tok_addr];
    voc_dout <= voc_mem[voc_addr];
    if (out_we) begin
      out_mem[out_addr] <= out_din;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int len, output int cycles, output int writes);
    int w0;
    w0 = wr_cnt;
    @(negedge clk);
    token_len = 5'(len);
    cs = 1'b1;
    @(negedge clk);
    cs = 1'b0;
    cycles = 1;
    while (!done && cycles < 300) begin
      @(negedge clk);
      cycles++;
    end
    check_val("no_timeout", 32'(cycles < 300), 32'd1);
    writes = wr_cnt - w0;
  endtask

  int cyc, wr;

  initial begin
    rst = 1'b1; cs = 1'b0; token_len = '0;
    for (int i = 0; i < 16; i++) begin
      tok_mem[i] = 8'h00; voc_mem[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_err", err, 0);
    check_val("rst_out_len", out_len, 0);
    check_val("rst_out_we", out_we, 0);
    check_val("rst_tok_addr", tok_addr, 0);
    check_val("rst_voc_addr", voc_addr, 0);
    rst = 1'b0;

    // literals only
    tok_mem[0] = 8'h41; tok_mem[1] = 8'h42;
    run(2, cyc, wr);
    check_val("lit_cycles", cyc, 7);
    check_val("lit_b0", out_mem[0], 8'h41);
    check_val("lit_b1", out_mem[1], 8'h42);
    check_val("lit_len", out_len, 2);
    check_val("lit_done", done, 1);
    check_val("lit_err", err, 0);
    check_val("lit_busy", busy, 0);
    check_val("lit_writes", wr, 2);

    // single merge
    voc_mem[0] = 8'h61; voc_mem[1] = 8'h62;
    tok_mem[0] = 8'd248;
    run(1, cyc, wr);
    check_val("m1_cycles", cyc, 8);
    check_val("m1_b0", out_mem[0], 8'h61);
    check_val("m1_b1", out_mem[1], 8'h62);
    check_val("m1_len", out_len, 2);
    check_val("m1_err", err, 0);

    // nested merge followed by a literal
    voc_mem[2] = 8'd248; voc_mem[3] = 8'h63;
    tok_mem[0] = 8'd249; tok_mem[1] = 8'h21;
    run(2, cyc, wr);
    check_val("nest_b0", out_mem[0], 8'h61);
    check_val("nest_b1", out_mem[1], 8'h62);
    check_val("nest_b2", out_mem[2], 8'h63);
    check_val("nest_b3", out_mem[3], 8'h21);
    check_val("nest_len", out_len, 4);
    check_val("nest_err", err, 0);
    check_val("nest_writes", wr, 4);

    // self-referencing merge grows the stack until it overflows
    voc_mem[4] = 8'd250; voc_mem[5] = 8'h00;
    tok_mem[0] = 8'd250;
    run(1, cyc, wr);
    check_val("sovf_err", err, 1);
    check_val("sovf_done", done, 1);
    check_val("sovf_len", out_len, 0);
    check_val("sovf_writes", wr, 0);

    // output SRAM overflow: nine 2-byte merges into 16 slots
    for (int i = 0; i < 9; i++) tok_mem[i] = 8'd248;
    run(9, cyc, wr);
    check_val("oovf_err", err, 1);
    check_val("oovf_done", done, 1);
    check_val("oovf_len", out_len, 16);
    check_val("oovf_writes", wr, 16);
    check_val("oovf_b14", out_mem[14], 8'h61);
    check_val("oovf_b15", out_mem[15], 8'h62);

    // empty token stream
    run(0, cyc, wr);
    check_val("zero_cycles", cyc, 1);
    check_val("zero_len", out_len, 0);
    check_val("zero_done", done, 1);
    check_val("zero_err", err, 0);

    // reset landing on the first EXPAND cycle
    tok_mem[0] = 8'h41; tok_mem[1] = 8'h42;
    @(negedge clk);
    token_len = 5'd2; cs = 1'b1;
    @(negedge clk);
    cs = 1'b0;
    repeat (2) @(negedge clk);
    check_val("mid_busy_pre", busy, 1);
    wr = wr_cnt;
    rst = 1'b1;
    #1;
    check_val("mid_out_we", out_we, 0);
    @(negedge clk);
    check_val("mid_busy", busy, 0);
    check_val("mid_done", done, 0);
    check_val("mid_writes", wr_cnt - wr, 0);
    rst = 1'b0;
    tok_mem[0] = 8'h51; tok_mem[1] = 8'h52;
    run(2, cyc, wr);
    check_val("post_cycles", cyc, 7);
    check_val("post_b0", out_mem[0], 8'h51);
    check_val("post_b1", out_mem[1], 8'h52);
    check_val("post_len", out_len, 2);
    check_val("post_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
